// File: rtl/bd_buf_pkg.sv
// Shared definitions for the per-channel BD buffer: command opcodes, FSM states
// and command-word field offsets.
package bd_buf_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [1:0] {
    OP_LOOKUP     = 2'b00,
    OP_REFILL     = 2'b01,
    OP_INVALIDATE = 2'b10,
    OP_RESERVED   = 2'b11
  } bd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MISS = 2'd1,
    ST_SEND = 2'd2
  } bd_state_e;

  // Command word is {addr, idx, op, mask}, mask in the LSBs.
  function automatic int unsigned cmd_op_lsb(input int unsigned depth);
    return depth;
  endfunction

  function automatic int unsigned cmd_idx_lsb(input int unsigned depth);
    return depth + OP_W;
  endfunction

  function automatic int unsigned cmd_addr_lsb(input int unsigned depth, input int unsigned idx_w);
    return depth + OP_W + idx_w;
  endfunction

  function automatic int unsigned cmd_width(input int unsigned depth, input int unsigned idx_w,
                                            input int unsigned addr_w);
    return addr_w + idx_w + OP_W + depth;
  endfunction

endpackage

// File: rtl/bd_buffer_channel_param_if.sv
// Command, BD output and refill streams of one DMA channel's BD buffer.
interface bd_buffer_channel_param_if
  import bd_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned BD_W   = 256,
  parameter int unsigned ADDR_W = 23
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CMD_W = cmd_width(DEPTH, IDX_W, ADDR_W);

  logic [CMD_W-1:0] cmd_tdata;
  logic             cmd_tvalid;
  logic             cmd_tready;

  logic [BD_W-1:0]  bd_out_tdata;
  logic [IDX_W-1:0] bd_out_tuser;
  logic             bd_out_tvalid;
  logic             bd_out_tready;

  logic [IDX_W-1:0] fill_tuser;
  logic [BD_W-1:0]  fill_tdata;
  logic             fill_tvalid;
  logic             fill_tlast;

  modport master (
    output cmd_tdata, cmd_tvalid,
    input  cmd_tready,
    input  bd_out_tdata, bd_out_tuser, bd_out_tvalid,
    output bd_out_tready,
    output fill_tuser, fill_tdata, fill_tvalid, fill_tlast
  );

  modport slave (
    input  cmd_tdata, cmd_tvalid,
    output cmd_tready,
    output bd_out_tdata, bd_out_tuser, bd_out_tvalid,
    input  bd_out_tready,
    input  fill_tuser, fill_tdata, fill_tvalid, fill_tlast
  );

endinterface

// File: rtl/bd_buf_ram.sv
// BD storage array: one write port, one combinational read port with
// write-first forwarding when both ports address the same entry.
module bd_buf_ram #(
  parameter int unsigned  DEPTH = 16,
  parameter int unsigned  BD_W  = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [BD_W-1:0]  wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [BD_W-1:0]  rd_data_c
);

  logic [BD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data_c = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

endmodule

// File: rtl/bd_buffer_channel_param.sv
// Per-channel BD store: serves lookups from the window, refills on a miss and
// streams the selected BD to the Response Queue with backpressure.
module bd_buffer_channel_param
  import bd_buf_pkg::*;
#(
  parameter int unsigned  DEPTH  = 16,
  parameter int unsigned  BD_W   = 256,
  parameter int unsigned  ADDR_W = 23,
  parameter int unsigned  CNT_W  = 16,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              user_clk,
  input  logic              user_reset_n,
  bd_buffer_channel_param_if.slave bus,
  output logic [ADDR_W-1:0] bd_buf_addr,
  output logic [DEPTH-1:0]  bd_buf_valid,
  output logic              lookup_err,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned OP_LSB   = cmd_op_lsb(DEPTH);
  localparam int unsigned IDX_LSB  = cmd_idx_lsb(DEPTH);
  localparam int unsigned ADDR_LSB = cmd_addr_lsb(DEPTH, IDX_W);

  bd_state_e        state;
  logic [IDX_W-1:0] idx_q;
  logic [BD_W-1:0]  out_data_q;
  logic [IDX_W-1:0] out_user_q;
  logic             out_valid_q;

  logic [ADDR_W-1:0] cmd_addr;
  logic [IDX_W-1:0]  cmd_idx;
  bd_op_e            cmd_op;
  logic [DEPTH-1:0]  cmd_mask;
  logic [IDX_W-1:0]  rd_idx;
  logic [BD_W-1:0]   rd_data;

  assign cmd_mask = bus.cmd_tdata[DEPTH-1:0];
  assign cmd_op   = bd_op_e'(bus.cmd_tdata[OP_LSB +: OP_W]);
  assign cmd_idx  = bus.cmd_tdata[IDX_LSB +: IDX_W];
  assign cmd_addr = bus.cmd_tdata[ADDR_LSB +: ADDR_W];

  assign bus.cmd_tready    = (state == ST_IDLE);
  assign bus.bd_out_tdata  = out_data_q;
  assign bus.bd_out_tuser  = out_user_q;
  assign bus.bd_out_tvalid = out_valid_q;

  // A lookup reads the commanded entry; a miss reads the entry latched at refill.
  assign rd_idx = (state == ST_MISS) ? idx_q : cmd_idx;

  bd_buf_ram #(
    .DEPTH (DEPTH),
    .BD_W  (BD_W)
  ) u_ram (
    .clk       (user_clk),
    .wr_en     (bus.fill_tvalid),
    .wr_idx    (bus.fill_tuser),
    .wr_data   (bus.fill_tdata),
    .rd_idx    (rd_idx),
    .rd_data_c (rd_data)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      state        <= ST_IDLE;
      idx_q        <= '0;
      out_data_q   <= '0;
      out_user_q   <= '0;
      out_valid_q  <= 1'b0;
      bd_buf_addr  <= '0;
      bd_buf_valid <= '0;
      lookup_err   <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      lookup_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cmd_tvalid) begin
            case (cmd_op)
              OP_LOOKUP: begin
                if (bd_buf_valid[cmd_idx]) begin
                  out_data_q  <= rd_data;
                  out_user_q  <= cmd_idx;
                  out_valid_q <= 1'b1;
                  idx_q       <= cmd_idx;
                  hit_cnt     <= sat_inc(hit_cnt);
                  state       <= ST_SEND;
                end else begin
                  lookup_err <= 1'b1;
                end
              end
              OP_REFILL: begin
                bd_buf_addr  <= cmd_addr;
                bd_buf_valid <= cmd_mask;
                idx_q        <= cmd_idx;
                miss_cnt     <= sat_inc(miss_cnt);
                state        <= ST_MISS;
              end
              OP_INVALIDATE: bd_buf_valid <= '0;
              default: ;
            endcase
          end
        end
        ST_MISS: begin
          if (bus.fill_tvalid && bus.fill_tlast) begin
            out_data_q  <= rd_data;
            out_user_q  <= idx_q;
            out_valid_q <= 1'b1;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          // Entry is consumed once the Response Queue takes it.
          if (bus.bd_out_tready) begin
            out_valid_q         <= 1'b0;
            bd_buf_valid[idx_q] <= 1'b0;
            state               <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bd_buffer_channel_param.sv
// Self-checking bench for bd_buffer_channel_param: table of per-cycle vectors
// with a BD scoreboard, plus reset-mid-SEND and counter saturation sequences.
module tb_bd_buffer_channel_param;
  import bd_buf_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned BD_W   = 256;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned CNT_W  = 2;

  typedef struct {
    logic        cv;
    logic [1:0]  op;
    logic [3:0]  idx;
    logic [22:0] addr;
    logic [15:0] mask;
    logic        fv;
    logic [3:0]  fidx;
    logic [7:0]  fdat;
    logic        fl;
    logic        rdy;
    logic        push;
    logic [7:0]  bd_dat;
    logic [3:0]  bd_usr;
    logic        e_err;
    logic        e_tv;
    logic        e_trdy;
    logic        chk;
    logic [15:0] e_vm;
    logic [22:0] e_addr;
    logic [1:0]  e_hit;
    logic [1:0]  e_miss;
  } vec_t;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   user;
  } bd_t;

  logic              user_clk;
  logic              user_reset_n;
  logic [ADDR_W-1:0] bd_buf_addr;
  logic [DEPTH-1:0]  bd_buf_valid;
  logic              lookup_err;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  int checks;
  int failures;
  bd_t  sb[$];
  vec_t tbl[$];

  bd_buffer_channel_param_if #(.DEPTH(DEPTH), .BD_W(BD_W), .ADDR_W(ADDR_W)) bus ();

  bd_buffer_channel_param #(
    .DEPTH  (DEPTH),
    .BD_W   (BD_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .bus          (bus),
    .bd_buf_addr  (bd_buf_addr),
    .bd_buf_valid (bd_buf_valid),
    .lookup_err   (lookup_err),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v_idle(input logic rdy);
    vec_t v;
    v = '{default: '0};
    v.rdy    = rdy;
    v.e_trdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_cmd(input bd_op_e op, input logic [3:0] idx, input logic [22:0] addr,
                                 input logic [15:0] mask, input logic rdy);
    vec_t v;
    v = v_idle(rdy);
    v.cv = 1'b1; v.op = op; v.idx = idx; v.addr = addr; v.mask = mask;
    return v;
  endfunction

  function automatic vec_t with_fill(input vec_t v0, input logic [3:0] fidx, input logic [7:0] fdat,
                                     input logic fl);
    vec_t v;
    v = v0;
    v.fv = 1'b1; v.fidx = fidx; v.fdat = fdat; v.fl = fl;
    return v;
  endfunction

  function automatic vec_t expect_st(input vec_t v0, input logic tv, input logic trdy);
    vec_t v;
    v = v0;
    v.e_tv = tv; v.e_trdy = trdy;
    return v;
  endfunction

  function automatic vec_t expect_err(input vec_t v0);
    vec_t v;
    v = v0;
    v.e_err = 1'b1;
    return v;
  endfunction

  function automatic vec_t expect_bd(input vec_t v0, input logic [7:0] dat, input logic [3:0] usr);
    vec_t v;
    v = v0;
    v.push = 1'b1; v.bd_dat = dat; v.bd_usr = usr;
    return v;
  endfunction

  function automatic vec_t with_stat(input vec_t v0, input logic [15:0] vm, input logic [22:0] addr,
                                     input logic [1:0] hit, input logic [1:0] miss);
    vec_t v;
    v = v0;
    v.chk = 1'b1; v.e_vm = vm; v.e_addr = addr; v.e_hit = hit; v.e_miss = miss;
    return v;
  endfunction

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.cmd_tdata     = '0;
    bus.cmd_tvalid    = 1'b0;
    bus.fill_tuser    = '0;
    bus.fill_tdata    = '0;
    bus.fill_tvalid   = 1'b0;
    bus.fill_tlast    = 1'b0;
    bus.bd_out_tready = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_cmd_tready"}, 256'(bus.cmd_tready), 256'(1));
    chk({tag, "_tvalid"}, 256'(bus.bd_out_tvalid), 256'(0));
    chk({tag, "_tdata"}, bus.bd_out_tdata, 256'(0));
    chk({tag, "_tuser"}, 256'(bus.bd_out_tuser), 256'(0));
    chk({tag, "_addr"}, 256'(bd_buf_addr), 256'(0));
    chk({tag, "_valid"}, 256'(bd_buf_valid), 256'(0));
    chk({tag, "_err"}, 256'(lookup_err), 256'(0));
    chk({tag, "_hit"}, 256'(hit_cnt), 256'(0));
    chk({tag, "_miss"}, 256'(miss_cnt), 256'(0));
  endtask

  // One clock: compare any held BD against the scoreboard, drive, then check.
  task automatic apply(input vec_t v, input int row);
    if (bus.bd_out_tvalid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bd[%0d] actual=tvalid required=no_bd", row);
      end else begin
        chk($sformatf("bd_data[%0d]", row), bus.bd_out_tdata, sb[0].data);
        chk($sformatf("bd_user[%0d]", row), 256'(bus.bd_out_tuser), 256'(sb[0].user));
        if (v.rdy) void'(sb.pop_front());
      end
    end
    bus.cmd_tdata     = {v.addr, v.idx, v.op, v.mask};
    bus.cmd_tvalid    = v.cv;
    bus.fill_tuser    = v.fidx;
    bus.fill_tdata    = 256'(v.fdat);
    bus.fill_tvalid   = v.fv;
    bus.fill_tlast    = v.fl;
    bus.bd_out_tready = v.rdy;
    if (v.push) sb.push_back('{data: 256'(v.bd_dat), user: v.bd_usr});
    tick();
    chk($sformatf("lookup_err[%0d]", row), 256'(lookup_err), 256'(v.e_err));
    chk($sformatf("tvalid[%0d]", row), 256'(bus.bd_out_tvalid), 256'(v.e_tv));
    chk($sformatf("cmd_tready[%0d]", row), 256'(bus.cmd_tready), 256'(v.e_trdy));
    if (v.chk) begin
      chk($sformatf("bd_buf_valid[%0d]", row), 256'(bd_buf_valid), 256'(v.e_vm));
      chk($sformatf("bd_buf_addr[%0d]", row), 256'(bd_buf_addr), 256'(v.e_addr));
      chk($sformatf("hit_cnt[%0d]", row), 256'(hit_cnt), 256'(v.e_hit));
      chk($sformatf("miss_cnt[%0d]", row), 256'(miss_cnt), 256'(v.e_miss));
    end
  endtask

  task automatic run_tbl(input int base);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], base + i);
    tbl.delete();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive_idle();
    user_reset_n = 1'b0;
    repeat (3) tick();
    reset_vals("por");
    user_reset_n = 1'b1;

    // Refill miss on idx 3 with a full 16-beat refill burst.
    tbl.push_back(with_stat(expect_st(v_cmd(OP_REFILL, 4'd3, 23'h12345, 16'hFFFF, 1'b0), 1'b0, 1'b0),
                            16'hFFFF, 23'h12345, 2'd0, 2'd1));
    for (int i = 0; i < 15; i++)
      tbl.push_back(expect_st(with_fill(v_idle(1'b0), 4'(i), 8'(i), 1'b0), 1'b0, 1'b0));
    tbl.push_back(expect_bd(expect_st(with_fill(v_idle(1'b0), 4'd15, 8'd15, 1'b1), 1'b1, 1'b0),
                            8'd3, 4'd3));
    tbl.push_back(with_stat(v_idle(1'b1), 16'hFFF7, 23'h12345, 2'd0, 2'd1));
    // Lookup hit held off by backpressure; a fill to the same entry must not leak through.
    tbl.push_back(with_stat(expect_bd(expect_st(v_cmd(OP_LOOKUP, 4'd5, '0, '0, 1'b0), 1'b1, 1'b0),
                                      8'd5, 4'd5), 16'hFFF7, 23'h12345, 2'd1, 2'd1));
    tbl.push_back(expect_st(v_idle(1'b0), 1'b1, 1'b0));
    tbl.push_back(expect_st(with_fill(v_idle(1'b0), 4'd5, 8'h55, 1'b0), 1'b1, 1'b0));
    tbl.push_back(expect_st(v_idle(1'b0), 1'b1, 1'b0));
    tbl.push_back(expect_st(v_idle(1'b0), 1'b1, 1'b0));
    tbl.push_back(with_stat(v_idle(1'b1), 16'hFFD7, 23'h12345, 2'd1, 2'd1));
    // Lookup of a consumed entry.
    tbl.push_back(expect_err(v_cmd(OP_LOOKUP, 4'd3, '0, '0, 1'b1)));
    tbl.push_back(v_idle(1'b1));
    // Lookup with a same-cycle fill to that entry forwards the new data.
    tbl.push_back(with_stat(expect_bd(expect_st(with_fill(v_cmd(OP_LOOKUP, 4'd7, '0, '0, 1'b0),
                                                          4'd7, 8'hAA, 1'b0), 1'b1, 1'b0),
                                      8'hAA, 4'd7), 16'hFFD7, 23'h12345, 2'd2, 2'd1));
    tbl.push_back(with_stat(v_idle(1'b1), 16'hFF57, 23'h12345, 2'd2, 2'd1));
    // Invalidate, then any lookup errors; reserved op changes nothing.
    tbl.push_back(with_stat(v_cmd(OP_INVALIDATE, 4'd0, '0, '0, 1'b1), 16'h0000, 23'h12345, 2'd2, 2'd1));
    tbl.push_back(expect_err(v_cmd(OP_LOOKUP, 4'd0, '0, '0, 1'b1)));
    tbl.push_back(v_idle(1'b1));
    tbl.push_back(with_stat(v_cmd(OP_RESERVED, 4'd9, 23'h7FFFFF, 16'hFFFF, 1'b1),
                            16'h0000, 23'h12345, 2'd2, 2'd1));
    tbl.push_back(v_idle(1'b1));
    run_tbl(0);

    // Reset while a BD is held in SEND; refill tlast forwards a same-cycle write.
    tbl.push_back(with_stat(expect_st(v_cmd(OP_REFILL, 4'd0, 23'h00ABC, 16'hFFFF, 1'b0), 1'b0, 1'b0),
                            16'hFFFF, 23'h00ABC, 2'd2, 2'd2));
    tbl.push_back(expect_bd(expect_st(with_fill(v_idle(1'b0), 4'd0, 8'h33, 1'b1), 1'b1, 1'b0),
                            8'h33, 4'd0));
    tbl.push_back(expect_st(v_idle(1'b0), 1'b1, 1'b0));
    run_tbl(100);
    chk("pre_reset_data", bus.bd_out_tdata, 256'h33);
    user_reset_n = 1'b0;
    drive_idle();
    bus.bd_out_tready = 1'b1;
    tick();
    reset_vals("mid_send");
    sb.delete();
    user_reset_n = 1'b1;
    tick();
    chk("dropped_bd_tvalid", 256'(bus.bd_out_tvalid), 256'(0));

    // Five hits against a 2-bit counter.
    tbl.push_back(with_stat(expect_st(v_cmd(OP_REFILL, 4'd0, 23'h00777, 16'hFFFF, 1'b0), 1'b0, 1'b0),
                            16'hFFFF, 23'h00777, 2'd0, 2'd1));
    tbl.push_back(expect_bd(expect_st(with_fill(v_idle(1'b0), 4'd0, 8'h33, 1'b1), 1'b1, 1'b0),
                            8'h33, 4'd0));
    tbl.push_back(with_stat(v_idle(1'b1), 16'hFFFE, 23'h00777, 2'd0, 2'd1));
    begin
      logic [15:0] vm;
      vm = 16'hFFFE;
      for (int k = 1; k <= 5; k++) begin
        logic [1:0] hit;
        hit = (k > 3) ? 2'd3 : 2'(k);
        tbl.push_back(with_stat(expect_bd(expect_st(v_cmd(OP_LOOKUP, 4'(k), '0, '0, 1'b1), 1'b1, 1'b0),
                                          (k == 5) ? 8'h55 : 8'(k), 4'(k)),
                                vm, 23'h00777, hit, 2'd1));
        vm[k] = 1'b0;
        tbl.push_back(with_stat(v_idle(1'b1), vm, 23'h00777, hit, 2'd1));
      end
    end
    run_tbl(200);

    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
